drink_vend_controller: RTL and testbench

Sequencing controller for the drink vending datapath. It accepts half-unit and one-unit coin pulses, accumulates credit in half-unit steps, and runs a 4-phase request/acknowledge handshake with the dispenser once credit reaches the price. It then pays out change one half-unit pulse at a time, and refunds all credit on cancel or idle timeout. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/drink_pkg.sv | 34 +++
 rtl/drink_idle_timer.sv | 39 +++
 rtl/drink_vend_controller.sv | 120 ++++++++++++
 tb/tb_drink_vend_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drink_pkg.sv
// Shared state encoding, coin values and widths for the drink vending controller.
package drink_pkg;

  localparam int CREDIT_W = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COLLECT   = 3'd1;
  localparam logic [2:0] ST_VEND_REQ  = 3'd2;
  localparam logic [2:0] ST_VEND_REL  = 3'd3;
  localparam logic [2:0] ST_CHG_PULSE = 3'd4;
  localparam logic [2:0] ST_CHG_GAP   = 3'd5;

  localparam logic [CREDIT_W-1:0] HALF_VAL = 4'd1;
  localparam logic [CREDIT_W-1:0] ONE_VAL  = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_COLLECT   = ST_COLLECT,
    S_VEND_REQ  = ST_VEND_REQ,
    S_VEND_REL  = ST_VEND_REL,
    S_CHG_PULSE = ST_CHG_PULSE,
    S_CHG_GAP   = ST_CHG_GAP
  } state_e;

  // Both coin pulses in one cycle simply add up.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic half, input logic one);
    logic [CREDIT_W-1:0] val;
    val = '0;
    if (half) val = val + HALF_VAL;
    if (one)  val = val + ONE_VAL;
    return val;
  endfunction

endpackage

// File: rtl/drink_idle_timer.sv
// Clearable down-counter that flags the cycle in which an idle period runs out.
module drink_idle_timer
  import drink_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = LOAD_VAL;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A clear in the same cycle (a fresh coin) wins over expiry.
  assign expire_o = enable_i && !clear_i && (count_q == '0);

endmodule

// File: rtl/drink_vend_controller.sv
// Coin credit accumulation, dispenser handshake and one-pulse-per-half-unit change payout.
module drink_vend_controller
  import drink_pkg::*;
#(
  parameter int PRICE_HALVES = 5,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int CHG_GAP      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_half,
  input  logic                coin_one,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic                vend_req,
  output logic                change_pulse,
  output logic                coin_block,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_HALVES);
  localparam int GAP_W = $clog2(CHG_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CHG_GAP - 1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                vend_req_q, change_pulse_q, busy_q;

  logic [CREDIT_W-1:0] credit_sum;
  logic                timer_clear, timer_en, timer_expire;

  assign timer_en    = (state_q == S_COLLECT);
  assign timer_clear = !timer_en || coin_half || coin_one;

  drink_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  // Next-state, credit and gap counter; coins are only looked at while not busy.
  always_comb begin
    credit_sum = credit_q + coin_value(coin_half, coin_one);
    state_d    = state_q;
    credit_d   = credit_q;
    gap_d      = gap_q;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        credit_d = credit_sum;
        if (cancel || timer_expire) begin
          state_d = (credit_sum != '0) ? S_CHG_PULSE : S_IDLE;
        end else if (credit_sum >= PRICE) begin
          state_d = S_VEND_REQ;
        end else if (credit_sum != '0) begin
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VEND_REQ: begin
        if (vend_ack) begin
          credit_d = credit_q - PRICE;
          state_d  = S_VEND_REL;
        end
      end
      S_VEND_REL: begin
        if (!vend_ack) begin
          state_d = (credit_q != '0) ? S_CHG_PULSE : S_IDLE;
        end
      end
      S_CHG_PULSE: begin
        credit_d = credit_q - CREDIT_W'(1);
        gap_d    = '0;
        state_d  = (credit_d != '0) ? S_CHG_GAP : S_IDLE;
      end
      S_CHG_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_CHG_PULSE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      gap_q          <= '0;
      vend_req_q     <= 1'b0;
      change_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      gap_q          <= gap_d;
      vend_req_q     <= (state_d == S_VEND_REQ);
      change_pulse_q <= (state_d == S_CHG_PULSE);
      busy_q         <= !((state_d == S_IDLE) || (state_d == S_COLLECT));
    end
  end

  assign vend_req     = vend_req_q;
  assign change_pulse = change_pulse_q;
  assign busy         = busy_q;
  assign coin_block   = busy_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_drink_vend_controller.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, then random traffic vs a model.
module tb_drink_vend_controller;

  localparam int PRICE = 5;
  localparam int TMO   = 8;
  localparam int GAP   = 2;

  typedef struct {
    logic       h;
    logic       o;
    logic       c;
    logic       a;
    logic       req;
    logic       chg;
    logic       bsy;
    logic [3:0] cr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       coinHalf, coinOne, cancelIn, vendAck;
  logic       vendReq, changePulse, coinBlock, busy;
  logic [3:0] credit;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  int mCredit, mPulses, mGap, mIdle;
  bit mReq, mRel;

  always #5 clk = ~clk;

  drink_vend_controller #(
    .PRICE_HALVES(PRICE),
    .TIMEOUT_CYC (TMO),
    .CHG_GAP     (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_half   (coinHalf),
    .coin_one    (coinOne),
    .cancel      (cancelIn),
    .vend_ack    (vendAck),
    .vend_req    (vendReq),
    .change_pulse(changePulse),
    .coin_block  (coinBlock),
    .busy        (busy),
    .credit      (credit)
  );

  function automatic logic [7:0] outs();
    return {vendReq, changePulse, busy, coinBlock, credit};
  endfunction

  function automatic logic [7:0] expPack(input logic req, input logic chg, input logic bsy,
                                         input logic [3:0] cr);
    return {req, chg, bsy, bsy, cr};
  endfunction

  function automatic vec_t mk(input logic h, input logic o, input logic c, input logic a,
                              input logic req, input logic chg, input logic bsy, input int cr);
    vec_t v;
    v.h = h; v.o = o; v.c = c; v.a = a;
    v.req = req; v.chg = chg; v.bsy = bsy; v.cr = 4'(cr);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: req/chg/busy/block/credit got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
               name, act[7], act[6], act[5], act[4], act[3:0], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then settle past the edge.
  task automatic applyStimulus(input logic h, input logic o, input logic c, input logic a);
    coinHalf = h; coinOne = o; cancelIn = c; vendAck = a;
    @(posedge clk);
    #1;
  endtask

  task automatic stepExpect(input string name, input logic h, input logic o, input logic c,
                            input logic a, input logic req, input logic chg, input logic bsy,
                            input int cr);
    applyStimulus(h, o, c, a);
    checkOutput(name, outs(), expPack(req, chg, bsy, 4'(cr)));
  endtask

  task automatic doReset();
    coinHalf = 0; coinOne = 0; cancelIn = 0; vendAck = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic modelReset();
    mCredit = 0; mPulses = 0; mGap = 0; mIdle = 0; mReq = 0; mRel = 0;
  endtask

  // Reference behaviour: a vend waits on ack levels, a refund is a count of pulses
  // with a countdown between them, otherwise coins add up and idle time is counted.
  task automatic modelStep(input bit h, input bit o, input bit c, input bit a);
    int total;
    total = mCredit + (h ? 1 : 0) + (o ? 2 : 0);
    if (mReq) begin
      if (a) begin
        mCredit -= PRICE; mReq = 0; mRel = 1;
      end
    end else if (mRel) begin
      if (!a) begin
        mRel = 0;
        if (mCredit > 0) begin
          mPulses = mCredit; mGap = 0;
        end
      end
    end else if (mPulses > 0) begin
      if (mGap == 0) begin
        mPulses--; mCredit--; mGap = GAP;
      end else begin
        mGap--;
      end
    end else begin
      if (h || o) mIdle = 0;
      else if (mCredit > 0) mIdle++;
      mCredit = total;
      if ((c || mIdle == TMO) && total > 0) begin
        mPulses = total; mGap = 0;
      end else if (total >= PRICE) begin
        mReq = 1;
      end
    end
  endtask

  function automatic logic [7:0] modelOut();
    logic bsy;
    bsy = mReq || mRel || (mPulses > 0);
    return expPack(mReq, (mPulses > 0) && (mGap == 0), bsy, 4'(mCredit));
  endfunction

  initial begin
    reset = 1'b0;
    coinHalf = 0; coinOne = 0; cancelIn = 0; vendAck = 0;
    #3;
    checkOutput("reset_state", outs(), expPack(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    // one,one,half -> vend with no change
    vecs.push_back(mk(0,1,0,0, 0,0,0,2));
    vecs.push_back(mk(0,1,0,0, 0,0,0,4));
    vecs.push_back(mk(1,0,0,0, 1,0,1,5));
    vecs.push_back(mk(0,0,0,1, 0,0,1,0));
    vecs.push_back(mk(0,0,0,1, 0,0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));
    // one,one,one -> vend, ignored coin during request, one change pulse
    vecs.push_back(mk(0,1,0,0, 0,0,0,2));
    vecs.push_back(mk(0,1,0,0, 0,0,0,4));
    vecs.push_back(mk(0,1,0,0, 1,0,1,6));
    vecs.push_back(mk(1,0,1,0, 1,0,1,6));
    vecs.push_back(mk(0,0,0,1, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,1,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));
    // both coins at once then cancel: three pulses spaced GAP+1 apart
    vecs.push_back(mk(1,1,0,0, 0,0,0,3));
    vecs.push_back(mk(0,0,1,0, 0,1,1,3));
    vecs.push_back(mk(0,1,0,0, 0,0,1,2));
    vecs.push_back(mk(0,0,1,0, 0,0,1,2));
    vecs.push_back(mk(0,0,0,0, 0,1,1,2));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,1,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));
    // credit 4 plus half+one -> 7, vend, two change pulses
    vecs.push_back(mk(0,1,0,0, 0,0,0,2));
    vecs.push_back(mk(0,1,0,0, 0,0,0,4));
    vecs.push_back(mk(1,1,0,0, 1,0,1,7));
    vecs.push_back(mk(0,0,0,1, 0,0,1,2));
    vecs.push_back(mk(0,0,0,0, 0,1,1,2));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,1,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));
    // cancel with no credit, coin+cancel together, stray ack while idle
    vecs.push_back(mk(0,0,1,0, 0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 0,1,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      stepExpect($sformatf("vec%0d", i), vecs[i].h, vecs[i].o, vecs[i].c, vecs[i].a,
                 vecs[i].req, vecs[i].chg, vecs[i].bsy, int'(vecs[i].cr));
    end

    // Idle timeout: refund starts exactly TMO cycles after the coin
    stepExpect("tmo_coin", 0, 1, 0, 0, 0, 0, 0, 2);
    for (int k = 1; k < TMO; k++) stepExpect($sformatf("tmo_wait%0d", k), 0, 0, 0, 0, 0, 0, 0, 2);
    stepExpect("tmo_pulse1", 0, 0, 0, 0, 0, 1, 1, 2);
    stepExpect("tmo_gap1a", 0, 0, 0, 0, 0, 0, 1, 1);
    stepExpect("tmo_gap1b", 0, 0, 0, 0, 0, 0, 1, 1);
    stepExpect("tmo_pulse2", 0, 0, 0, 0, 0, 1, 1, 1);
    stepExpect("tmo_done", 0, 0, 0, 0, 0, 0, 0, 0);

    // A later coin restarts the idle count; cancel coinciding with timeout is one refund
    stepExpect("rst_coin1", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) stepExpect($sformatf("rst_waitA%0d", k), 0, 0, 0, 0, 0, 0, 0, 1);
    stepExpect("rst_coin2", 1, 0, 0, 0, 0, 0, 0, 2);
    for (int k = 1; k < TMO; k++) stepExpect($sformatf("rst_waitB%0d", k), 0, 0, 0, 0, 0, 0, 0, 2);
    stepExpect("both_pulse1", 0, 0, 1, 0, 0, 1, 1, 2);
    stepExpect("both_gapa", 0, 0, 0, 0, 0, 0, 1, 1);
    stepExpect("both_gapb", 0, 0, 0, 0, 0, 0, 1, 1);
    stepExpect("both_pulse2", 0, 0, 0, 0, 0, 1, 1, 1);
    stepExpect("both_done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-request drops outputs without waiting for a clock
    stepExpect("mid_coin1", 0, 1, 0, 0, 0, 0, 0, 2);
    stepExpect("mid_coin2", 0, 1, 0, 0, 0, 0, 0, 4);
    stepExpect("mid_coin3", 1, 0, 0, 0, 1, 0, 1, 5);
    coinHalf = 0; coinOne = 0; cancelIn = 0; vendAck = 0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_async", outs(), expPack(0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("mid_reset_held", outs(), expPack(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    stepExpect("post_coin1", 0, 1, 0, 0, 0, 0, 0, 2);
    stepExpect("post_coin2", 0, 1, 0, 0, 0, 0, 0, 4);
    stepExpect("post_coin3", 1, 0, 0, 0, 1, 0, 1, 5);
    stepExpect("post_ack", 0, 0, 0, 1, 0, 0, 1, 0);
    stepExpect("post_rel", 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the reference model
    doReset();
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      logic h, o, c, a;
      h = ($urandom_range(0, 4) == 0);
      o = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 2) == 0);
      modelStep(h, o, c, a);
      applyStimulus(h, o, c, a);
      checkOutput($sformatf("rand%0d", n), outs(), modelOut());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
